// File: rtl/fht_loader_pkg.sv
// rtl/fht_loader_pkg.sv - shared types and bank-select helper for the FHT ADC loader
//
// Contents:
//   state_t  - loader FSM states (IDLE, FILL, GAP, START, BUSY)
//   bank_we  - one-hot write enable for a fill-order bank, using the
//              bit-reversed bank index that fht_top expects
package fht_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        GAP   = 3'd2,
        START = 3'd3,
        BUSY  = 3'd4
    } state_t;

    // The loader fills banks in counter order 0,1,2,3. fht_top wants them in
    // bit-reversed order, so counter bank b lands on RAM bank {b[0],b[1]}.
    function automatic logic [3:0] bank_we(input logic [1:0] bank);
        logic [3:0] we;
        we = 4'b0000;
        we[{bank[0], bank[1]}] = 1'b1;
        return we;
    endfunction

endpackage

// File: rtl/fht_adc_loader.sv
// rtl/fht_adc_loader.sv - loads one ADC frame into the fht_top input banks and fires iSTART
//
// Ports:
//   iCLK, iRESET      - clock, synchronous active-high reset
//   iEN               - capture enable, looked at in IDLE and when leaving BUSY
//   iSAMPLE, iVALID   - signed ADC sample stream (D_BIT-1 bits)
//   iRDY              - oRDY of fht_top; its rising edge ends BUSY
//   oDATA, oADDR_WR   - registered write data / bank address to fht_top
//   oWE[3:0]          - one-hot bank write strobe (oWE[k] -> fht_top.iWE_k)
//   oSTART            - one-cycle transform start pulse
//   oBUSY             - high whenever the loader is not IDLE
//   oOVF_CNT          - samples dropped while waiting on the FHT (saturating)
//   oFRAME_CNT        - frames started (wrapping)
module fht_adc_loader
    import fht_loader_pkg::*;
#(
    parameter int D_BIT     = 16,
    parameter int A_BIT     = 8,
    parameter int START_GAP = 2
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iEN,
    input  logic [D_BIT-2:0]   iSAMPLE,
    input  logic               iVALID,
    input  logic               iRDY,
    output logic [D_BIT-2:0]   oDATA,
    output logic [A_BIT-1:0]   oADDR_WR,
    output logic [3:0]         oWE,
    output logic               oSTART,
    output logic               oBUSY,
    output logic [15:0]        oOVF_CNT,
    output logic [15:0]        oFRAME_CNT
);

    // Sample counter spans the whole frame: top two bits pick the bank.
    localparam logic [A_BIT+1:0] LAST_N   = '1;
    localparam int               GAP_W    = (START_GAP > 1) ? $clog2(START_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((START_GAP > 0) ? START_GAP - 1 : 0);

    state_t           state;
    logic [A_BIT+1:0] n;
    logic [GAP_W-1:0] gap_cnt;
    logic             rdy_q;
    logic             rdy_rise;
    logic             drop;

    assign rdy_rise = iRDY & ~rdy_q;
    // Samples are lost only while a captured frame is waiting on the FHT;
    // IDLE deliberately ignores the stream.
    assign drop     = iVALID & ((state == GAP) | (state == START) | (state == BUSY));

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state      <= IDLE;
            n          <= '0;
            gap_cnt    <= '0;
            rdy_q      <= 1'b0;
            oDATA      <= '0;
            oADDR_WR   <= '0;
            oWE        <= 4'b0000;
            oSTART     <= 1'b0;
            oBUSY      <= 1'b0;
            oOVF_CNT   <= 16'h0000;
            oFRAME_CNT <= 16'h0000;
        end else begin
            rdy_q  <= iRDY;
            oWE    <= 4'b0000;
            oSTART <= 1'b0;

            if (drop && (oOVF_CNT != 16'hFFFF))
                oOVF_CNT <= oOVF_CNT + 16'd1;

            case (state)
                IDLE: begin
                    if (iEN) begin
                        state <= FILL;
                        n     <= '0;
                        oBUSY <= 1'b1;
                    end
                end

                FILL: begin
                    if (iVALID) begin
                        oDATA    <= iSAMPLE;
                        oADDR_WR <= n[A_BIT-1:0];
                        oWE      <= bank_we(n[A_BIT+1:A_BIT]);
                        n        <= n + 1'b1;
                        if (n == LAST_N) begin
                            gap_cnt <= '0;
                            if (START_GAP == 0) begin
                                // No settle time wanted: start alongside the last write.
                                state      <= START;
                                oSTART     <= 1'b1;
                                oFRAME_CNT <= oFRAME_CNT + 16'd1;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                end

                GAP: begin
                    // oSTART is registered together with the move to START, so
                    // it lands START_GAP cycles after the last oWE pulse.
                    if (gap_cnt == GAP_LAST) begin
                        state      <= START;
                        oSTART     <= 1'b1;
                        oFRAME_CNT <= oFRAME_CNT + 16'd1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                START: begin
                    state <= BUSY;
                end

                BUSY: begin
                    if (rdy_rise) begin
                        if (iEN) begin
                            state <= FILL;
                            n     <= '0;
                        end else begin
                            state <= IDLE;
                            oBUSY <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    oBUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fht_adc_loader.sv
// tb/tb_fht_adc_loader.sv - randomized self-checking bench for fht_adc_loader
module tb_fht_adc_loader;

    localparam int D_BIT     = 16;
    localparam int A_BIT     = 3;
    localparam int START_GAP = 2;
    localparam int BANK      = 1 << A_BIT;
    localparam int FRAME     = 4 * BANK;

    logic              iCLK = 1'b0;
    logic              iRESET = 1'b1;
    logic              iEN = 1'b0;
    logic [D_BIT-2:0]  iSAMPLE = '0;
    logic              iVALID = 1'b0;
    logic              iRDY = 1'b0;
    logic [D_BIT-2:0]  oDATA;
    logic [A_BIT-1:0]  oADDR_WR;
    logic [3:0]        oWE;
    logic              oSTART;
    logic              oBUSY;
    logic [15:0]       oOVF_CNT;
    logic [15:0]       oFRAME_CNT;

    fht_adc_loader #(
        .D_BIT(D_BIT),
        .A_BIT(A_BIT),
        .START_GAP(START_GAP)
    ) dut (
        .iCLK(iCLK),
        .iRESET(iRESET),
        .iEN(iEN),
        .iSAMPLE(iSAMPLE),
        .iVALID(iVALID),
        .iRDY(iRDY),
        .oDATA(oDATA),
        .oADDR_WR(oADDR_WR),
        .oWE(oWE),
        .oSTART(oSTART),
        .oBUSY(oBUSY),
        .oOVF_CNT(oOVF_CNT),
        .oFRAME_CNT(oFRAME_CNT)
    );

    always #5 iCLK = ~iCLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [D_BIT-2:0] src [FRAME];
    int               order [4] = '{0, 2, 1, 3};
    int               frames_exp = 0;
    int               ovf_exp = 0;
    bit               exp_we_next = 1'b0;
    logic [D_BIT-2:0] exp_data = '0;

    // Observed RAM image and event times
    logic [D_BIT-2:0] ram_dut [FRAME];
    int               cyc = 0;
    int               last_we = 0;
    int               start_at = 0;
    bit               start_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [D_BIT-2:0] rnd_sample();
        logic [31:0] r;
        r = $urandom;
        return r[D_BIT-2:0];
    endfunction

    // Advance to the next falling edge, capture writes and start pulses, and
    // confirm a write strobe appears exactly when one was expected.
    task automatic tick();
        int idx;
        @(negedge iCLK);
        cyc++;
        check("we_pulse", 32'(oWE != 4'b0000), 32'(exp_we_next));
        if (exp_we_next)
            check("data_lat", 32'(oDATA), 32'(exp_data));
        exp_we_next = 1'b0;
        if (oWE != 4'b0000) begin
            check("we_onehot", 32'($countones(oWE)), 32'd1);
            idx = 0;
            for (int k = 0; k < 4; k++)
                if (oWE[k]) idx = k;
            ram_dut[idx * BANK + int'(oADDR_WR)] = oDATA;
            last_we = cyc;
        end
        if (oSTART) begin
            start_seen = 1'b1;
            start_at   = cyc;
        end
    endtask

    task automatic set_src(input bit randomized);
        for (int k = 0; k < FRAME; k++)
            src[k] = randomized ? rnd_sample() : (D_BIT-1)'(k);
    endtask

    task automatic start_capture();
        iEN    = 1'b1;
        iVALID = 1'b0;
        tick();
        check("busy_rise", 32'(oBUSY), 32'd1);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid and iEN
    task automatic drive_frame(input int mode, input int nsamp);
        int acc   = 0;
        int guard = 0;
        bit v     = 1'b0;
        for (int k = 0; k < FRAME; k++) ram_dut[k] = 'x;
        start_seen = 1'b0;
        while (acc < nsamp && guard < 400) begin
            tick();
            guard++;
            case (mode)
                0:       v = 1'b1;
                1:       v = ~v;
                default: begin
                    v   = 1'($urandom_range(1));
                    iEN = 1'($urandom_range(1));
                end
            endcase
            iVALID  = v;
            iSAMPLE = v ? src[acc] : rnd_sample();
            if (v) begin
                exp_we_next = 1'b1;
                exp_data    = src[acc];
                acc++;
            end
        end
        if (acc < nsamp) check("fill_timeout", 32'(acc), 32'(nsamp));
    endtask

    task automatic post_frame(input bit gap_rand, input int nbusy, input bit en_after);
        int g = 0;
        bit v;
        while (!start_seen && g < 20) begin
            tick();
            g++;
            v       = gap_rand ? 1'($urandom_range(1)) : 1'b0;
            iVALID  = v;
            iSAMPLE = rnd_sample();
            if (v) ovf_exp++;
        end
        if (!start_seen) check("start_timeout", 32'd0, 32'd1);
        else             check("start_gap", 32'(start_at - last_we), 32'(START_GAP));
        frames_exp++;
        check("frame_cnt", 32'(oFRAME_CNT), 32'(frames_exp));
        repeat (nbusy) begin
            tick();
            iVALID  = 1'b1;
            iSAMPLE = rnd_sample();
            ovf_exp++;
        end
        tick();
        iVALID = 1'b0;
        iEN    = en_after;
        iRDY   = 1'b1;
        tick();
        iRDY = 1'b0;
        tick();
        check("ovf_cnt", 32'(oOVF_CNT), 32'(ovf_exp));
        check("busy_after", 32'(oBUSY), 32'(en_after));
    endtask

    task automatic check_ram();
        for (int k = 0; k < FRAME; k++)
            check("ram", 32'(ram_dut[order[k / BANK] * BANK + (k % BANK)]), 32'(src[k]));
    endtask

    task automatic check_reset_outputs();
        check("rst_data",  32'(oDATA),      32'd0);
        check("rst_addr",  32'(oADDR_WR),   32'd0);
        check("rst_we",    32'(oWE),        32'd0);
        check("rst_start", 32'(oSTART),     32'd0);
        check("rst_busy",  32'(oBUSY),      32'd0);
        check("rst_ovf",   32'(oOVF_CNT),   32'd0);
        check("rst_frame", 32'(oFRAME_CNT), 32'd0);
    endtask

    initial begin
        // 1: reset, then a disabled loader ignores the stream entirely
        iRESET = 1'b1;
        repeat (3) tick();
        iRESET = 1'b0;
        tick();
        check_reset_outputs();
        repeat (100) begin
            tick();
            iVALID  = 1'b1;
            iSAMPLE = rnd_sample();
        end
        tick();
        iVALID = 1'b0;
        tick();
        check("idle_ovf",  32'(oOVF_CNT), 32'd0);
        check("idle_busy", 32'(oBUSY),    32'd0);

        // 2: ramp 0..31 back-to-back, continue straight into the next frame
        set_src(1'b0);
        start_capture();
        drive_frame(0, FRAME);
        post_frame(1'b0, 0, 1'b1);
        check_ram();

        // 3 + 4: ramp with iVALID toggling, five dropped samples while busy
        drive_frame(1, FRAME);
        post_frame(1'b0, 5, 1'b1);
        check_ram();

        // random data, random valid, iEN wobbling during fill; end in IDLE
        set_src(1'b1);
        drive_frame(2, FRAME);
        post_frame(1'b1, 4, 1'b0);
        check_ram();

        // 5: reset after 13 samples discards the partial frame
        repeat (5) begin
            tick();
            iVALID  = 1'b1;
            iSAMPLE = rnd_sample();
        end
        set_src(1'b1);
        start_capture();
        drive_frame(0, 13);
        tick();
        iRESET = 1'b1;
        iVALID = 1'b1;
        tick();
        iRESET = 1'b0;
        iVALID = 1'b0;
        iEN    = 1'b0;
        check_reset_outputs();
        frames_exp = 0;
        ovf_exp    = 0;

        // 6: sign handling on a full frame after the reset
        set_src(1'b1);
        src[0] = 15'h7FFF;
        src[1] = 15'h4000;
        src[2] = 15'h3FFF;
        start_capture();
        drive_frame(0, FRAME);
        post_frame(1'b1, 3, 1'b1);
        check_ram();

        // a few more random frames back to back
        for (int f = 0; f < 3; f++) begin
            set_src(1'b1);
            drive_frame(2, FRAME);
            post_frame(1'b1, $urandom_range(6), 1'b1);
            check_ram();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
